// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision post-adder: FSM encoding,
// raw-sum bit positions and exponent constants.
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CARRY_BIT  = 27;
  localparam int HIDDEN_BIT = 26;
  localparam int GUARD_BIT  = 2;

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam logic [7:0] EXP_BIAS = 8'd127;

endpackage

// File: rtl/lzc28.sv
// 28-bit leading-zero counter; returns 28 for an all-zero input.
module lzc28 (
  input  logic [27:0] i_d,
  output logic [4:0]  o_cnt
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    o_cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      o_cnt = i_d[i] ? 5'(27 - i) : o_cnt;
    end
  end

endmodule

// File: rtl/post_adder.sv
// Normalise and round a raw single-precision sum into a packed IEEE-754 word.
// Define POST_ADDER_FAST_NORM_EN for a one-cycle leading-zero/barrel-shift NORM.
module post_adder
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        S_In,
  input  logic [7:0]  E_In,
  input  logic [27:0] M_In,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        OF,
  output logic        NX
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_s;
  logic [8:0]  r_e;
  logic [27:0] r_m;
  logic [31:0] r_result;
  logic        r_of;
  logic        r_nx;

  logic        w_zero;
  logic        w_carry;
  logic        w_at_min;
  logic        w_norm_done;
  logic [27:0] w_m_norm;
  logic [8:0]  w_e_norm;

  logic        w_inc;
  logic [24:0] w_sum;
  logic [23:0] w_mant;
  logic [8:0]  w_e_rnd;
  logic [31:0] w_result;
  logic        w_of;
  logic        w_nx;

  assign w_zero   = (r_m == 28'd0);
  assign w_carry  = r_m[CARRY_BIT];
  assign w_at_min = (r_e == 9'd1);

`ifdef POST_ADDER_FAST_NORM_EN
  logic [4:0] w_lz;
  logic [8:0] w_lz_m1;
  logic [8:0] w_e_m1;
  logic [8:0] w_shamt;

  lzc28 u_lzc28 (
    .i_d   (r_m),
    .o_cnt (w_lz)
  );

  // Shift needed to reach the hidden bit, capped so the exponent stops at 1.
  assign w_lz_m1 = {4'd0, w_lz} - 9'd1;
  assign w_e_m1  = r_e - 9'd1;
  assign w_shamt = (w_lz_m1 < w_e_m1) ? w_lz_m1 : w_e_m1;
`endif

  // Normalisation step for the current NORM cycle.
  always_comb begin
    w_m_norm    = r_m;
    w_e_norm    = r_e;
    w_norm_done = 1'b1;
    if (w_carry) begin
      w_m_norm = {1'b0, r_m[27:2], r_m[1] | r_m[0]};
      w_e_norm = r_e + 9'd1;
    end else if (r_m[HIDDEN_BIT] || w_at_min || w_zero) begin
      w_norm_done = 1'b1;
    end else begin
`ifdef POST_ADDER_FAST_NORM_EN
      w_m_norm    = r_m << w_shamt;
      w_e_norm    = r_e - w_shamt;
      w_norm_done = 1'b1;
`else
      w_m_norm    = {r_m[26:0], 1'b0};
      w_e_norm    = r_e - 9'd1;
      w_norm_done = 1'b0;
`endif
    end
  end

  // Round-to-nearest-even and result packing.
  always_comb begin
    w_inc  = r_m[GUARD_BIT] & (r_m[GUARD_BIT-1] | r_m[0] | r_m[GUARD_BIT+1]);
    w_sum  = {1'b0, r_m[HIDDEN_BIT:GUARD_BIT+1]} + {24'd0, w_inc};
    w_nx   = |r_m[GUARD_BIT:0];
    if (w_sum[24]) begin
      w_mant  = w_sum[24:1];
      w_e_rnd = r_e + 9'd1;
    end else begin
      w_mant  = w_sum[23:0];
      w_e_rnd = r_e;
    end
    if (w_zero) begin
      w_result = {r_s, 31'h0};
      w_of     = 1'b0;
    end else if (w_e_rnd >= {1'b0, EXP_MAX}) begin
      w_result = {r_s, EXP_MAX, 23'h0};
      w_of     = 1'b1;
    end else begin
      // A clear hidden bit can only remain at E=1: subnormal encoding.
      w_result = {r_s, (w_mant[23] ? w_e_rnd[7:0] : 8'd0), w_mant[22:0]};
      w_of     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = in_valid ? ST_NORM : ST_IDLE;
      ST_NORM:  w_state_nxt = w_norm_done ? ST_ROUND : ST_NORM;
      ST_ROUND: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = out_ready ? ST_IDLE : ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE:  in_ready  = 1'b1;
      ST_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, normalisation updates and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s      <= 1'b0;
      r_e      <= 9'd0;
      r_m      <= 28'd0;
      r_result <= 32'h0;
      r_of     <= 1'b0;
      r_nx     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_s <= S_In;
            r_e <= {1'b0, E_In};
            r_m <= M_In;
          end
        end
        ST_NORM: begin
          r_m <= w_m_norm;
          r_e <= w_e_norm;
        end
        ST_ROUND: begin
          r_result <= w_result;
          r_of     <= w_of;
          r_nx     <= w_nx & ~w_zero;
        end
        default: begin
          r_result <= r_result;
        end
      endcase
    end
  end

  assign Result = r_result;
  assign OF     = r_of;
  assign NX     = r_nx;

endmodule

// File: tb/tb_post_adder.sv
// Self-checking bench for post_adder: directed table, corner sequences and
// randomized operands compared with an arithmetic reference model.
module tb_post_adder;

`ifdef POST_ADDER_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S_In;
  logic [7:0]  E_In;
  logic [27:0] M_In;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        OF;
  logic        NX;

  int n_checks = 0;
  int n_fail   = 0;

  post_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S_In      (S_In),
    .E_In      (E_In),
    .M_In      (M_In),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .OF        (OF),
    .NX        (NX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] res;
    bit          of;
    bit          nx;
    int          k;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Value-level model: normalise by multiplying/dividing by two, round on the
  // three low bits as a fraction of one LSB.
  function automatic void ref_model(input bit s, input int e, input longint m,
                                    output logic [31:0] res, output bit of,
                                    output bit nx, output int k);
    longint     mm;
    longint     q;
    int         ee;
    int         grs;
    logic [7:0] ef;
    mm = m; ee = e; k = 0; of = 1'b0; nx = 1'b0;
    if (mm == 0) begin
      res = {s, 31'h0};
      return;
    end
    if (mm >= (64'd1 << 27)) begin
      mm = (mm >> 1) | (mm & 1);
      ee++;
    end else begin
      while (mm < (64'd1 << 26) && ee > 1) begin
        mm = mm * 2;
        ee--;
        k++;
      end
    end
    grs = int'(mm % 8);
    q   = mm / 8;
    nx  = (grs != 0);
    if (grs > 4 || (grs == 4 && (q % 2) == 1)) q++;
    if (q >= (64'd1 << 24)) begin
      q = q / 2;
      ee++;
    end
    if (ee >= 255) begin
      res = {s, 8'hFF, 23'h0};
      of  = 1'b1;
    end else begin
      ef  = (q >= (64'd1 << 23)) ? 8'(ee) : 8'd0;
      res = {s, ef, q[22:0]};
    end
    if (FAST) k = 0;
  endfunction

  task automatic do_op(input bit s, input logic [7:0] e, input logic [27:0] m,
                       output logic [31:0] res, output bit of, output bit nx,
                       output int lat);
    S_In = s; E_In = e; M_In = m; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    res = Result; of = OF; nx = NX;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [31:0] g_res, e_res, held;
  bit          g_of, g_nx, e_of, e_nx;
  int          g_lat, e_k;
  bit          seen;

  initial begin
    tbl[0]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 23};
    tbl[2]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b1, 0};
    tbl[3]  = '{1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b1, 8'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 0};
    tbl[6]  = '{1'b0, 8'd1,   28'h0000010, 32'h00000002, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b1, 0};
    tbl[9]  = '{1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 1'b1, 1'b1, 0};
    tbl[10] = '{1'b1, 8'd3,   28'h0800000, 32'h80400000, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b0, 8'd100, 28'h8000001, 32'h32800000, 1'b0, 1'b1, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    S_In = 1'b0; E_In = 8'd0; M_In = 28'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", Result, 32'h0);
    check("reset_of", {31'd0, OF}, 32'd0);
    check("reset_nx", {31'd0, NX}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].s, tbl[i].e, tbl[i].m, g_res, g_of, g_nx, g_lat);
      check($sformatf("tbl%0d_result", i), g_res, tbl[i].res);
      check($sformatf("tbl%0d_of", i), {31'd0, g_of}, {31'd0, tbl[i].of});
      check($sformatf("tbl%0d_nx", i), {31'd0, g_nx}, {31'd0, tbl[i].nx});
      check($sformatf("tbl%0d_latency", i), 32'(g_lat), FAST ? 32'd2 : 32'(tbl[i].k + 2));
      check($sformatf("tbl%0d_idle", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result must hold while the consumer stalls.
    S_In = 1'b0; E_In = 8'd127; M_In = 28'h8000000; in_valid = 1'b1;
    @(posedge clk); #1;
    S_In = 1'b1; E_In = 8'd5; M_In = 28'h0000123;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    check("bp_out_valid_rise", {31'd0, seen}, 32'd1);
    held = Result;
    check("bp_result", held, 32'h40000000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_result", Result, 32'h40000000);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_transfer_valid", {31'd0, out_valid}, 32'd0);
    check("bp_transfer_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_no_accept", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a long normalisation discards the operation.
    S_In = 1'b0; E_In = 8'd127; M_In = 28'h0000008; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_result", Result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_pulse", {31'd0, seen}, 32'd0);

    // Randomized operands against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic        rs;
      logic [7:0]  re;
      logic [27:0] rm;
      rs = 1'($urandom);
      re = 8'($urandom_range(1, 254));
      if ($urandom_range(0, 3) == 0) re = 8'($urandom_range(1, 8));
      rm = 28'($urandom) >> $urandom_range(0, 27);
      if ($urandom_range(0, 19) == 0) rm = 28'd0;
      ref_model(rs, int'(re), longint'(rm), e_res, e_of, e_nx, e_k);
      do_op(rs, re, rm, g_res, g_of, g_nx, g_lat);
      check($sformatf("rnd%0d_result(e=%0d m=%h)", n, re, rm), g_res, e_res);
      check($sformatf("rnd%0d_flags", n), {30'd0, g_of, g_nx}, {30'd0, e_of, e_nx});
      check($sformatf("rnd%0d_latency", n), 32'(g_lat), 32'(e_k + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/post_adder.md
POST_ADDER -- requirements
Module: post_adder

Interface
REQ-001 SHALL have no parameters; all widths are fixed for IEEE-754 single precision.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the raw sum on S_In/E_In/M_In is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a new sum.
REQ-006 SHALL have port S_In, input, 1 bit: result sign, decided upstream, including the sign of a zero result.
REQ-007 SHALL have port E_In, input, 8 bits: biased exponent of the larger operand, 1..254; upstream maps subnormals to 1.
REQ-008 SHALL have port M_In, input, 28 bits: raw sum; [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 SHALL have port out_valid, output, 1 bit: Result and the flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port Result, output, 32 bits: packed IEEE-754 single result.
REQ-012 SHALL have port OF, output, 1 bit: overflow to infinity.
REQ-013 SHALL have port NX, output, 1 bit: the result is inexact.

Function
REQ-014 SHALL implement the FSM IDLE -> NORM -> ROUND -> DONE -> IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE, and SHALL capture S/E/M on in_valid & in_ready, then go to NORM.
REQ-016 NORM, when M[27]=1: SHALL shift right 1, OR the bit shifted out into the sticky bit, E+1, go to ROUND.
REQ-017 NORM, when M[26]=1, E=1, or M=0: SHALL go to ROUND without shifting.
REQ-018 NORM, otherwise: SHALL shift left 1 (zero fill), E-1, stay in NORM; one shift per cycle.
REQ-019 ROUND SHALL apply round-to-nearest-even: increment when G & (R | S | LSB).
REQ-020 SHALL set NX = G | R | S before rounding.
REQ-021 A rounding carry out of the hidden bit SHALL cause mantissa >> 1 and E+1.
REQ-022 SHALL output exponent 0 when hidden = 0 at E=1 (subnormal or zero); a rounding carry into the hidden bit at E=1 SHALL yield exponent 1.
REQ-023 An exponent reaching 255 (at NORM or ROUND) SHALL give Result = {S,8'hFF,23'h0} with OF=1.
REQ-024 M=0 SHALL give Result = {S_In,31'h0} with NX=0.
REQ-025 ROUND SHALL register Result/OF/NX and go to DONE; out_valid = 1 only in DONE.
REQ-026 DONE SHALL hold Result, OF and NX stable until out_ready=1, then go to IDLE; no new input is accepted in the same cycle.
REQ-027 Latency: out_valid SHALL rise k+2 cycles after the accept edge, k = number of left shifts (0..26).

Reset
REQ-028 While rst=1, the state SHALL be IDLE; Result=0, OF=0, NX=0, out_valid=0, in_ready=1.
REQ-029 Reset during NORM, ROUND or DONE SHALL discard the operation, with no output pulse after release.

Configuration
REQ-030 With POST_ADDER_FAST_NORM_EN defined: a leading-zero count plus barrel shift SHALL complete NORM in one cycle.
REQ-031 With POST_ADDER_FAST_NORM_EN defined: the left shift SHALL be capped at E-1, so k counts as 0 and latency is always 2.
REQ-032 Without POST_ADDER_FAST_NORM_EN: NORM SHALL be the iterative behaviour of REQ-016..REQ-018.
REQ-033 Result, OF and NX SHALL be identical in both builds.

Structure
REQ-034 A shared package fpu_pkg SHALL hold:
- FSM state encoding;
- bit positions CARRY_BIT=27, HIDDEN_BIT=26, GUARD_BIT=2;
- EXP_MAX=8'hFF and EXP_BIAS=127.
REQ-035 One sub-module, lzc28 (28-bit leading-zero counter), SHALL be instantiated only under POST_ADDER_FAST_NORM_EN; the rounding stays inline.

Verification
REQ-036 E_In=127, M_In=28'h8000000 (1.0+1.0) SHALL give Result=32'h40000000, OF=0, NX=0, latency 2.
REQ-037 E_In=127, M_In=28'h0000008 SHALL give Result=32'h34000000.
- Iterative build: latency 25 (k=23).
- Fast build: latency 2.
REQ-038 E_In=127, M_In=28'h400000C (tie, LSB=1) SHALL give Result=32'h3F800002, NX=1.
REQ-039 E_In=254, M_In=28'h8000000 SHALL give Result=32'h7F800000, OF=1.
REQ-040 Backpressure: out_ready=0 for 5 cycles SHALL hold out_valid=1, Result stable, in_ready=0; transfer happens on the out_ready=1 edge.
REQ-041 M_In=0, S_In=1 SHALL give Result=32'h80000000.
REQ-042 rst pulsed mid-NORM (iterative build) SHALL give IDLE and out_valid=0 until the next accept.
